// File: rtl/cpu_control.sv
// cpu_control: main opcode decoder for the single-cycle core, plus a sticky halt-state flag.
// Latency: the decode outputs are combinational (zero cycles). halted is registered and is set one rising edge after a HLT opcode.
// Backpressure: none. Once halted, all state-changing controls are held at 0 until a synchronous reset.
//
// Ports:
//   clk, rst   system clock; synchronous active-high reset, which clears halted
//   control    opcode, instruction bits [15:12]
//   RegRead, MemRead, MemtoReg[1:0], MemWrite, ALUOp[2:0], ALUsrc,
//   RegWrite, PCSour[1:0], LH, HLT   datapath controls
//   halted     registered sticky halt state
module cpu_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] control,
  output logic       RegRead,
  output logic       MemRead,
  output logic [1:0] MemtoReg,
  output logic       MemWrite,
  output logic [2:0] ALUOp,
  output logic       ALUsrc,
  output logic       RegWrite,
  output logic [1:0] PCSour,
  output logic       LH,
  output logic       HLT,
  output logic       halted
);

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_LLB = 4'b1010;
  localparam logic [3:0] OP_LHB = 4'b1011;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Reset takes priority, so a HLT sampled together with rst is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (control == OP_HLT) begin
      halted <= 1'b1;
    end
  end

  always_comb begin
    RegRead  = 1'b0;
    MemRead  = 1'b0;
    MemtoReg = 2'b00;
    MemWrite = 1'b0;
    ALUOp    = 3'b000;
    ALUsrc   = 1'b0;
    RegWrite = 1'b0;
    PCSour   = 2'b00;
    LH       = 1'b0;
    HLT      = 1'b0;

    if (halted) begin
      // Frozen: keep the PC on hold and signal halt, regardless of the opcode.
      HLT    = 1'b1;
      PCSour = 2'b01;
    end else if (control[3] == 1'b0) begin
      // ALU group: the ALU operation is the low three opcode bits.
      // The shift/rotate ops (01xx except PADDSB 0111) take an immediate operand.
      RegRead  = 1'b1;
      RegWrite = 1'b1;
      MemtoReg = 2'b10;
      ALUOp    = control[2:0];
      ALUsrc   = (control[2] == 1'b1) && (control[1:0] != 2'b11);
    end else begin
      case (control)
        OP_LW: begin
          RegRead  = 1'b1;
          MemRead  = 1'b1;
          ALUsrc   = 1'b1;
          RegWrite = 1'b1;
          MemtoReg = 2'b11;
        end
        OP_SW: begin
          RegRead  = 1'b1;
          MemWrite = 1'b1;
          ALUsrc   = 1'b1;
        end
        OP_LLB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
        end
        OP_LHB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
          LH       = 1'b1;
        end
        OP_B: begin
          PCSour = 2'b11;
        end
        OP_BR: begin
          RegRead = 1'b1;
          PCSour  = 2'b01;
        end
        OP_PCS: begin
          RegWrite = 1'b1;
        end
        default: begin
          // OP_HLT: the only opcode left in the 1xxx space.
          HLT    = 1'b1;
          PCSour = 2'b01;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
module tb_cpu_control;

  logic       clk;
  logic       rst;
  logic [3:0] control;
  logic       RegRead, MemRead, MemWrite, ALUsrc, RegWrite, LH, HLT, halted;
  logic [1:0] MemtoReg, PCSour;
  logic [2:0] ALUOp;

  int checks   = 0;
  int failures = 0;

  logic [14:0] exp_tab [16];
  logic [14:0] halt_v;

  cpu_control dut (
    .clk(clk), .rst(rst), .control(control),
    .RegRead(RegRead), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .ALUOp(ALUOp), .ALUsrc(ALUsrc),
    .RegWrite(RegWrite), .PCSour(PCSour), .LH(LH), .HLT(HLT),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Packing order: RegRead MemRead MemtoReg MemWrite ALUOp ALUsrc RegWrite PCSour LH HLT halted
  function automatic logic [14:0] pk(input logic rr, input logic mr, input logic [1:0] mtr,
                                     input logic mw, input logic [2:0] aop, input logic as,
                                     input logic rw, input logic [1:0] pcs, input logic lh,
                                     input logic hlt, input logic h);
    return {rr, mr, mtr, mw, aop, as, rw, pcs, lh, hlt, h};
  endfunction

  function automatic logic [14:0] observed();
    return {RegRead, MemRead, MemtoReg, MemWrite, ALUOp, ALUsrc, RegWrite, PCSour, LH, HLT, halted};
  endfunction

  task automatic check(input string tag, input logic [14:0] exp);
    logic [14:0] got;
    got = observed();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  initial begin
    //                  rr   mr   mtr    mw   aop     as   rw   pcs    lh   hlt  h
    exp_tab[0]  = pk(1'b1, 1'b0, 2'b10, 1'b0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // ADD
    exp_tab[1]  = pk(1'b1, 1'b0, 2'b10, 1'b0, 3'b001, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // SUB
    exp_tab[2]  = pk(1'b1, 1'b0, 2'b10, 1'b0, 3'b010, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // XOR
    exp_tab[3]  = pk(1'b1, 1'b0, 2'b10, 1'b0, 3'b011, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // RED
    exp_tab[4]  = pk(1'b1, 1'b0, 2'b10, 1'b0, 3'b100, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // SLL
    exp_tab[5]  = pk(1'b1, 1'b0, 2'b10, 1'b0, 3'b101, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // SRA
    exp_tab[6]  = pk(1'b1, 1'b0, 2'b10, 1'b0, 3'b110, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // ROR
    exp_tab[7]  = pk(1'b1, 1'b0, 2'b10, 1'b0, 3'b111, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // PADDSB
    exp_tab[8]  = pk(1'b1, 1'b1, 2'b11, 1'b0, 3'b000, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // LW
    exp_tab[9]  = pk(1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); // SW
    exp_tab[10] = pk(1'b0, 1'b0, 2'b01, 1'b0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // LLB
    exp_tab[11] = pk(1'b0, 1'b0, 2'b01, 1'b0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0); // LHB
    exp_tab[12] = pk(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0); // B
    exp_tab[13] = pk(1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0); // BR
    exp_tab[14] = pk(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // PCS
    exp_tab[15] = pk(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0); // HLT
    halt_v      = pk(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1);

    // Reset: halted cleared, decode follows control (ADD).
    rst = 1'b1;
    control = 4'b0000;
    @(posedge clk); #1;
    check("reset_add", exp_tab[0]);
    rst = 1'b0;

    // Sweep all opcodes between two edges (16 x 2 time units inside a 100-unit period).
    for (int i = 0; i < 16; i++) begin
      control = 4'(i);
      #2;
      check($sformatf("sweep_op%0d", i), exp_tab[i]);
    end

    // HLT was only present between edges, so halted must not have been set.
    control = 4'b0000;
    @(posedge clk); #1;
    check("hlt_between_edges_ignored", exp_tab[0]);

    // Take HLT at an edge, then apply ADD: the outputs are forced to the halt set.
    control = 4'b1111;
    @(posedge clk); #1;
    control = 4'b0000;
    #1;
    check("halted_add_suppressed", halt_v);
    control = 4'b1001;
    #1;
    check("halted_sw_suppressed", halt_v);
    @(posedge clk); #1;
    check("halted_sticky", halt_v);

    // Reset while halted: normal decode resumes right after the edge.
    rst = 1'b1;
    control = 4'b0000;
    @(posedge clk); #1;
    check("reset_clears_halt", exp_tab[0]);
    rst = 1'b0;
    #1;
    check("post_reset_add", exp_tab[0]);

    // HLT together with rst: HLT is shown combinationally, but halted stays 0.
    rst = 1'b1;
    control = 4'b1111;
    #1;
    check("hlt_during_rst_comb", exp_tab[15]);
    @(posedge clk); #1;
    check("hlt_with_rst_not_halted", exp_tab[15]);
    rst = 1'b0;
    @(posedge clk); #1;
    check("hlt_after_rst_halted", halt_v);
    control = 4'b0101;
    #1;
    check("halted_sra_suppressed", halt_v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
